// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM bank: register map, CTRL bit
// positions and the count-direction enum used by center-aligned mode.
package pwm_pkg;

  localparam int ADDR_TOP        = 0;
  localparam int ADDR_CTRL       = 1;
  localparam int ADDR_DUTY0      = 2;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CENTER_BIT = 1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty register, comparator against the
// shared counter and the registered output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm
);

  logic [CNT_W-1:0] duty_shadow;
  logic [CNT_W-1:0] duty_active;
  logic [CNT_W-1:0] duty_next;
  logic             pwm_q;

  // A write landing on a load edge must be the value that goes active.
  assign duty_next = wr ? wr_data : duty_shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_shadow <= '0;
      duty_active <= '0;
      pwm_q       <= 1'b0;
    end else begin
      duty_shadow <= duty_next;
      if (load) begin
        duty_active <= duty_next;
      end
      pwm_q <= en && (cnt < duty_active);
    end
  end

  assign pwm = pwm_q & en;

endmodule

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one edge/center-aligned counter.
// Center-aligned mode is built only when PWM_CENTER_ALIGN_EN is defined.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int CNT_W  = 8,
  localparam int ADDR_W = $clog2(NUM_CH + 2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CNT_W-1:0]  wr_data,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_end_o,
  output logic [CNT_W-1:0]  cnt_o
);

  logic             wr_top;
  logic             wr_ctrl;
  logic [CNT_W-1:0] top_shadow;
  logic [CNT_W-1:0] top_active;
  logic [CNT_W-1:0] top_next;
  logic             en_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] edge_next;
  logic             load;

  assign wr_top    = wr_en && (wr_addr == ADDR_W'(ADDR_TOP));
  assign wr_ctrl   = wr_en && (wr_addr == ADDR_W'(ADDR_CTRL));
  assign top_next  = wr_top ? wr_data : top_shadow;
  assign edge_next = (cnt_q >= top_active) ? '0 : cnt_q + 1'b1;

`ifdef PWM_CENTER_ALIGN_EN
  logic center_q;
  logic mode_restart;
  dir_e dir_q;
  dir_e dir_next;

  // Flipping CENTER while running restarts the sweep on the following edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      center_q     <= 1'b0;
      mode_restart <= 1'b0;
      dir_q        <= DIR_UP;
    end else begin
      if (wr_ctrl) begin
        center_q <= wr_data[CTRL_CENTER_BIT];
      end
      mode_restart <= wr_ctrl && en_q && (wr_data[CTRL_CENTER_BIT] != center_q);
      dir_q        <= dir_next;
    end
  end

  always_comb begin
    cnt_next = '0;
    dir_next = DIR_UP;
    if (!en_q || mode_restart) begin
      cnt_next = '0;
    end else if (center_q) begin
      if (top_active == '0) begin
        cnt_next = '0;
      end else if (dir_q == DIR_UP && cnt_q < top_active) begin
        cnt_next = cnt_q + 1'b1;
      end else if (cnt_q > CNT_W'(1)) begin
        cnt_next = cnt_q - 1'b1;
        dir_next = DIR_DOWN;
      end else begin
        cnt_next = '0;
      end
    end else begin
      cnt_next = edge_next;
    end
  end
`else
  always_comb begin
    cnt_next = '0;
    if (en_q) begin
      cnt_next = edge_next;
    end
  end
`endif

  // Shadows move to active at the wrap back to 0, or continuously when idle.
  assign load         = !en_q || (cnt_next == '0);
  assign period_end_o = en_q && (cnt_next == '0);
  assign cnt_o        = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_shadow <= '0;
      top_active <= '0;
      en_q       <= 1'b0;
      cnt_q      <= '0;
    end else begin
      top_shadow <= top_next;
      if (load) begin
        top_active <= top_next;
      end
      if (wr_ctrl) begin
        en_q <= wr_data[CTRL_EN_BIT];
      end
      cnt_q <= cnt_next;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr      (wr_en && (wr_addr == ADDR_W'(ADDR_DUTY0 + i))),
      .wr_data (wr_data),
      .load    (load),
      .en      (en_q),
      .cnt     (cnt_q),
      .pwm     (pwm_o[i])
    );
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank with default parameters.
// Center-mode expectations apply when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_bank;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [3:0] pwm_o;
  logic       period_end_o;
  logic [7:0] cnt_o;

  int assertions = 0;
  int failures   = 0;

  pwm_bank dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pwm_o        (pwm_o),
    .period_end_o (period_end_o),
    .cnt_o        (cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    assertions++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clk);
    wr_addr = addr;
    wr_data = data;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Runs one period from cnt==0 back to cnt==0, optionally writing DUTY[0]
  // when cnt equals wr_at. highs counts pwm_o[0] lagged one cycle behind cnt.
  task automatic measurePeriod(input int wr_at, input logic [7:0] wr_val,
                               output int highs, output int len,
                               output int pes, output int others);
    int guard;
    highs  = 0;
    len    = 0;
    pes    = 0;
    others = 0;
    guard  = 0;
    while (cnt_o != 8'd0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) checkOutput("wait_cnt0_timeout", int'(cnt_o), 0);
    for (int n = 0; n < 100; n++) begin
      pes += int'(period_end_o);
      if (int'(cnt_o) == wr_at) begin
        wr_addr = 3'd2;
        wr_data = wr_val;
        wr_en   = 1'b1;
      end else begin
        wr_en   = 1'b0;
      end
      @(negedge clk);
      highs += int'(pwm_o[0]);
      if (pwm_o[3:1] != 3'b000) others++;
      len++;
      if (cnt_o == 8'd0) break;
    end
    wr_en = 1'b0;
    if (cnt_o != 8'd0) checkOutput("period_timeout", int'(cnt_o), 0);
  endtask

  initial begin
    int hi0, hi1, hi2, hi3, pe_cnt;
    int highs, len, pes, others;

    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    #2;
    checkOutput("reset_pwm", int'(pwm_o), 0);
    checkOutput("reset_cnt", int'(cnt_o), 0);
    checkOutput("reset_period_end", int'(period_end_o), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_cnt", int'(cnt_o), 0);
    checkOutput("idle_pwm", int'(pwm_o), 0);

    // Edge mode, TOP=9, duties 3 / 0 / 10 / 5 across three periods.
    applyStimulus(3'd0, 8'd9);
    applyStimulus(3'd2, 8'd3);
    applyStimulus(3'd3, 8'd0);
    applyStimulus(3'd4, 8'd10);
    applyStimulus(3'd5, 8'd5);
    checkOutput("disabled_cnt", int'(cnt_o), 0);
    applyStimulus(3'd1, 8'd1);
    hi0 = 0; hi1 = 0; hi2 = 0; hi3 = 0; pe_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      checkOutput($sformatf("edge_cnt_k%0d", k), int'(cnt_o), k % 10);
      pe_cnt += int'(period_end_o);
      if (k >= 1) begin
        hi0 += int'(pwm_o[0]);
        hi1 += int'(pwm_o[1]);
        hi2 += int'(pwm_o[2]);
        hi3 += int'(pwm_o[3]);
      end
      @(negedge clk);
    end
    checkOutput("duty3_highs", hi0, 9);
    checkOutput("duty0_highs", hi1, 0);
    checkOutput("duty10_highs", hi2, 29);
    checkOutput("duty5_highs", hi3, 15);
    checkOutput("period_end_pulses", pe_cnt, 3);

    // Duty update mid-period only affects the following period.
    measurePeriod(5, 8'd7, highs, len, pes, others);
    checkOutput("wr_at5_cur_highs", highs, 3);
    checkOutput("wr_at5_cur_len", len, 10);
    checkOutput("wr_at5_cur_pe", pes, 1);
    measurePeriod(-1, 8'd0, highs, len, pes, others);
    checkOutput("wr_at5_next_highs", highs, 7);
    measurePeriod(0, 8'd3, highs, len, pes, others);
    checkOutput("wr_at0_cur_highs", highs, 7);
    measurePeriod(9, 8'd7, highs, len, pes, others);
    checkOutput("wr_at9_cur_highs", highs, 3);
    measurePeriod(-1, 8'd0, highs, len, pes, others);
    checkOutput("wr_at9_next_highs", highs, 7);

    // TOP=4, DUTY=2 with CENTER requested.
    applyStimulus(3'd1, 8'd0);
    applyStimulus(3'd0, 8'd4);
    applyStimulus(3'd2, 8'd2);
    applyStimulus(3'd1, 8'd3);
    measurePeriod(-1, 8'd0, highs, len, pes, others);
`ifdef PWM_CENTER_ALIGN_EN
    // Sweep 0,1,2,3,4,3,2,1: cnt<2 holds at 0, 1 and the trailing 1.
    checkOutput("center_len", len, 8);
    checkOutput("center_highs", highs, 3);
`else
    checkOutput("center_ignored_len", len, 5);
    checkOutput("center_ignored_highs", highs, 2);
`endif
    checkOutput("center_pe", pes, 1);

    // Asynchronous reset while pwm_o[0] is high.
    @(negedge clk);
    checkOutput("pre_reset_pwm", int'(pwm_o[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_pwm", int'(pwm_o), 0);
    checkOutput("async_reset_cnt", int'(cnt_o), 0);
    checkOutput("async_reset_pe", int'(period_end_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_reset_pwm", int'(pwm_o), 0);
    checkOutput("post_reset_cnt", int'(cnt_o), 0);
    checkOutput("post_reset_pe", int'(period_end_o), 0);

    // Re-enable with TOP=0 after reset: counter holds, period_end every cycle.
    applyStimulus(3'd1, 8'd1);
    checkOutput("top0_cnt", int'(cnt_o), 0);
    checkOutput("top0_pe", int'(period_end_o), 1);
    @(negedge clk);
    checkOutput("top0_pe_again", int'(period_end_o), 1);
    applyStimulus(3'd0, 8'd9);
    applyStimulus(3'd2, 8'd3);
    measurePeriod(-1, 8'd0, highs, len, pes, others);
    checkOutput("rerun_len", len, 10);
    checkOutput("rerun_highs", highs, 3);

    // Out-of-range address must not disturb any channel.
    applyStimulus(3'd6, 8'hFF);
    applyStimulus(3'd7, 8'hFF);
    measurePeriod(-1, 8'd0, highs, len, pes, others);
    checkOutput("bad_addr_len", len, 10);
    checkOutput("bad_addr_highs", highs, 3);
    checkOutput("bad_addr_others", others, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
